// File: rtl/minimig_autoconfig_chain.sv
// AutoConfig chain: presents each enabled virtual board in turn in the $E8xxxx
// config space, then records the base address it is given or the shut-up.
module minimig_autoconfig_chain #(
  parameter int          NUM_BOARDS   = 3,
  parameter logic [15:0] MANUFACTURER = 16'h07DB,
  parameter logic [31:0] SERIAL       = 32'h0000_0001
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk7_en,
  input  logic [6:0]                address_in,
  input  logic [15:0]               data_in,
  input  logic                      rd,
  input  logic                      hwr,
  input  logic                      lwr,
  input  logic                      sel,
  input  logic [NUM_BOARDS-1:0]     board_enable,
  input  logic [NUM_BOARDS-1:0]     board_zorro3,
  input  logic [3*NUM_BOARDS-1:0]   board_size,
  input  logic [8*NUM_BOARDS-1:0]   board_product,
  output logic [15:0]               data_out,
  output logic                      config_out,
  output logic [NUM_BOARDS-1:0]     board_configured,
  output logic [NUM_BOARDS-1:0]     board_shutup,
  output logic [16*NUM_BOARDS-1:0]  board_base
);

  localparam int IDX_W = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                  state_r;
  logic [IDX_W-1:0]        cur_r;
  logic [NUM_BOARDS-1:0]   en_snap_r;
  logic [15:0]             base_r    [NUM_BOARDS];
  logic [2:0]              size_s    [NUM_BOARDS];
  logic [7:0]              product_s [NUM_BOARDS];

  logic [7:0]       offset_s;
  logic             zorro3_s;
  logic [7:0]       type_s;
  logic [7:0]       flags_s;
  logic [7:0]       prod_s;
  logic [31:0]      serial_s;
  logic [3:0]       nibble_s;
  logic             wr_s;
  logic             cfg_hit_s;
  logic             shut_hit_s;
  logic [IDX_W:0]   first_s;
  logic [IDX_W:0]   next_s;
  logic             unused_s;

  // Returns {found, index} of the lowest enabled slot at or above start.
  function automatic logic [IDX_W:0] find_from(input logic [NUM_BOARDS-1:0] en,
                                               input int start);
    logic [IDX_W:0] res;
    res = {(IDX_W+1){1'b0}};
    for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
      if (i >= start && en[i]) begin
        res = {1'b1, IDX_W'(i)};
      end
    end
    return res;
  endfunction

  for (genvar g = 0; g < NUM_BOARDS; g++) begin : g_slot
    assign size_s[g]               = board_size[3*g +: 3];
    assign product_s[g]            = board_product[8*g +: 8];
    assign board_base[16*g +: 16]  = base_r[g];
  end

  assign offset_s   = {address_in, 1'b0};
  assign zorro3_s   = board_zorro3[cur_r];
  assign wr_s       = clk7_en & sel & (hwr | lwr);
  assign cfg_hit_s  = zorro3_s ? (offset_s == 8'h44) : (offset_s == 8'h48);
  assign shut_hit_s = (offset_s == 8'h4C);
  assign first_s    = find_from(board_enable, 0);
  assign next_s     = find_from(en_snap_r, int'(cur_r) + 1);
  assign unused_s   = rd;

  // Descriptor nibble for the current board at the addressed offset.
  always_comb begin
    type_s   = {(zorro3_s ? 2'b10 : 2'b11), 3'b100, size_s[cur_r]};
    flags_s  = zorro3_s ? 8'h20 : 8'h00;
    prod_s   = product_s[cur_r];
    serial_s = SERIAL + {{(32-IDX_W){1'b0}}, cur_r};
    case (offset_s)
      8'h00:   nibble_s = type_s[7:4];
      8'h02:   nibble_s = type_s[3:0];
      8'h04:   nibble_s = ~prod_s[7:4];
      8'h06:   nibble_s = ~prod_s[3:0];
      8'h08:   nibble_s = ~flags_s[7:4];
      8'h0A:   nibble_s = ~flags_s[3:0];
      8'h10:   nibble_s = ~MANUFACTURER[15:12];
      8'h12:   nibble_s = ~MANUFACTURER[11:8];
      8'h14:   nibble_s = ~MANUFACTURER[7:4];
      8'h16:   nibble_s = ~MANUFACTURER[3:0];
      8'h18:   nibble_s = ~serial_s[31:28];
      8'h1A:   nibble_s = ~serial_s[27:24];
      8'h1C:   nibble_s = ~serial_s[23:20];
      8'h1E:   nibble_s = ~serial_s[19:16];
      8'h20:   nibble_s = ~serial_s[15:12];
      8'h22:   nibble_s = ~serial_s[11:8];
      8'h24:   nibble_s = ~serial_s[7:4];
      8'h26:   nibble_s = ~serial_s[3:0];
      default: nibble_s = 4'hF;
    endcase
  end

  assign data_out = (sel && state_r == ST_ACTIVE) ? {nibble_s, 12'hFFF} : 16'h0000;

  // Chain sequencing: snapshot enables, then walk boards on each accepted write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= ST_INIT;
      cur_r            <= {IDX_W{1'b0}};
      en_snap_r        <= {NUM_BOARDS{1'b0}};
      config_out       <= 1'b0;
      board_configured <= {NUM_BOARDS{1'b0}};
      board_shutup     <= {NUM_BOARDS{1'b0}};
      for (int i = 0; i < NUM_BOARDS; i++) begin
        base_r[i] <= 16'h0000;
      end
    end else begin
      case (state_r)
        ST_INIT: begin
          en_snap_r <= board_enable;
          if (first_s[IDX_W]) begin
            cur_r   <= first_s[IDX_W-1:0];
            state_r <= ST_ACTIVE;
          end else begin
            state_r    <= ST_DONE;
            config_out <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (wr_s && (cfg_hit_s || shut_hit_s)) begin
            if (cfg_hit_s) begin
              base_r[cur_r]           <= zorro3_s ? data_in : {8'h00, data_in[15:8]};
              board_configured[cur_r] <= 1'b1;
            end else begin
              board_shutup[cur_r] <= 1'b1;
            end
            if (next_s[IDX_W]) begin
              cur_r <= next_s[IDX_W-1:0];
            end else begin
              state_r    <= ST_DONE;
              config_out <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          config_out <= 1'b1;
        end
        default: begin
          state_r <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: doc/minimig_autoconfig_chain.md
Name: minimig_autoconfig_chain

Overview:
Parametrised Zorro II/III AutoConfig controller that presents up to NUM_BOARDS virtual expansion boards, one at a time, in the $E80000 config space. Board descriptors come from ports, so the chain is built at run time. A write to the base-address register assigns that board's address; a write to shut-up retires it. The block then advances to the next enabled board. Sits beside the Gary/CPU address decoder; sel is the decoded $E8xxxx config-space strobe.

Parameters:
NUM_BOARDS, 3, number of board slots (1..8)
MANUFACTURER, 16'h07DB, er_Manufacturer reported by every board
SERIAL, 32'h0000_0001, er_SerialNumber base; board i reports SERIAL+i

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
clk7_en  in  1  7 MHz bus-cycle enable
address_in  in  7  CPU address bits 7:1
data_in  in  16  CPU write data
rd  in  1  CPU read
hwr  in  1  CPU high-byte write
lwr  in  1  CPU low-byte write
sel  in  1  config-space select
board_enable  in  NUM_BOARDS  slot i present; sampled only in INIT
board_zorro3  in  NUM_BOARDS  1 = Zorro III board, 0 = Zorro II
board_size  in  3*NUM_BOARDS  er_Type size code per slot
board_product  in  8*NUM_BOARDS  product ID per slot
data_out  out  16  read nibble in [15:12], [11:0] = 12'hFFF; 16'h0000 when sel=0 or DONE
config_out  out  1  high when chain exhausted (DONE)
board_configured  out  NUM_BOARDS  slot i assigned an address
board_shutup  out  NUM_BOARDS  slot i shut up
board_base  out  16*NUM_BOARDS  assigned base address; ZII: A23:A16 in [7:0], [15:8] = 0; ZIII: A31:A16

Behaviour:
- Reset: state=INIT; board_configured, board_shutup, board_base, config_out all 0; enable snapshot cleared.
- INIT (exactly 1 clk): latch board_enable into en_snap. cur = lowest i with en_snap[i]=1, go to ACTIVE. If none, go to DONE.
- ACTIVE(cur): reads decode offset {address_in,1'b0}, combinational, gated by sel. Field bytes:
  - er_Type = {zorro3 ? 2'b10 : 2'b11, 1'b1 (memlist), 1'b0, 1'b0, size[2:0]}
  - er_Product = product
  - er_Flags = zorro3 ? 8'h20 : 8'h00
  - Offsets: $00/$02 = er_Type high/low nibble, not inverted.
  - $04/$06 = product nibbles, inverted.
  - $08/$0A = flags nibbles, inverted.
  - $10..$16 = manufacturer nibbles MSB first, inverted.
  - $18..$26 = serial nibbles MSB first, inverted.
  - All other offsets = 4'hF.
- Write qualifier: clk7_en & sel & (hwr|lwr).
  - ZII board, write to $48: board_base[cur] = {8'h00, data_in[15:8]}; set board_configured[cur]; advance.
  - ZIII board, write to $44: board_base[cur] = data_in[15:0]; set board_configured[cur]; advance.
  - Write to $48 on a ZIII board: ignored.
  - Write to $4C: set board_shutup[cur]; base unchanged; advance.
  - Other offsets: ignored.
- Advance, same clk as the write: cur = lowest i > cur with en_snap[i]. If none, go to DONE. Reads reflect the new board from the next clk.
- DONE: data_out = 16'h0000; config_out=1; all writes ignored. Stays until reset.
- Writes with clk7_en=0 have no effect. At most one advance per clk7_en cycle.
- board_enable changes after INIT: ignored until next reset.
- Reset mid-chain: everything returns to reset values; the chain restarts from INIT.

Test Plan:
- enable=3'b011, slot0 ZII size 3'b110, product 8'h0A → $00 nibble=4'hE, $02=4'h6, $04=4'hF, $06=4'h5, $10=4'hF; data_out[11:0]=12'hFFF.
- Write $48 data 16'h2000 (clk7_en=1) → board_configured=3'b001, board_base[0]=16'h0020. Next clk, slot1 descriptor visible at $00.
- Slot1 ZIII, write $44 data 16'h4000 → board_base[1]=16'h4000, board_configured=3'b011, config_out=1, data_out=16'h0000.
- enable=3'b101: write $4C → board_shutup=3'b001, base[0]=0. Slot2 becomes active; slot1 skipped.
- enable=3'b000 → DONE 1 clk after reset release; config_out=1; a $48 write changes nothing.
- Same write with clk7_en=0 → no state change. Assert reset while slot1 is active → all outputs 0; slot0 active again after INIT.
